// File: rtl/gigatron_video_pkg.sv
// gigatron_video_pkg: state encoding, default timing
// and out-register bit positions for the video sampler.
package gigatron_video_pkg;

  typedef enum logic [1:0] {
    VS_SEARCH,
    VS_HLOCK,
    VS_WAIT_V,
    VS_RUN
  } vs_state_e;

  localparam int DEF_H_TOTAL    = 200;
  localparam int DEF_H_BP       = 11;
  localparam int DEF_H_VIS      = 160;
  localparam int DEF_V_TOTAL    = 521;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_V_VIS      = 480;
  localparam int DEF_LOCK_LINES = 4;

  localparam int OUT_HSYNC = 6;
  localparam int OUT_VSYNC = 7;

endpackage

// File: rtl/gigatron_sync_edge.sv
// gigatron_sync_edge: one-bit sample register and
// rising-edge detector for an active-low sync line.
module gigatron_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic q;

  // Sample holds high out of reset so a low line is never an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b1;
    else          q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/gigatron_video_sampler.sv
// gigatron_video_sampler: locks onto Gigatron sync timing
// and emits a coordinate-tagged RGB222 pixel stream.
module gigatron_video_sampler
  import gigatron_video_pkg::*;
#(
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int H_BP       = DEF_H_BP,
  parameter int H_VIS      = DEF_H_VIS,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int V_BP       = DEF_V_BP,
  parameter int V_VIS      = DEF_V_VIS,
  parameter int LOCK_LINES = DEF_LOCK_LINES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] out_in,
  output logic       pix_valid,
  output logic [5:0] pix_rgb,
  output logic [7:0] pix_x,
  output logic [8:0] pix_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       sync_err,
  output logic       locked
);

  localparam logic [7:0] H_END  = 8'(H_TOTAL);
  localparam logic [7:0] H_LAST = 8'(H_TOTAL - 1);
  localparam logic [7:0] H_LO   = 8'(H_BP);
  localparam logic [7:0] H_HI   = 8'(H_BP + H_VIS);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_LO   = 10'(V_BP);
  localparam logic [9:0] V_HI   = 10'(V_BP + V_VIS);
  localparam logic [2:0] LOCK_N = 3'(LOCK_LINES);

  logic       hrise;
  logic       vrise;
  logic [5:0] s0_rgb;
  logic [7:0] hcount;
  logic [9:0] vcount;
  logic       vpend;
  logic [2:0] lockcnt;
  logic [2:0] lock_n;
  vs_state_e  state;
  vs_state_e  state_n;
  logic       err_n;
  logic       ls_n;
  logic       fs_n;
  logic       run_ok;
  logic       good;
  logic       bad;
  logic       timeout;
  logic       vzero;
  logic       overrun;
  logic       pix_vis;

  gigatron_sync_edge u_hs (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (out_in[OUT_HSYNC]),
    .rise    (hrise)
  );

  gigatron_sync_edge u_vs (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (out_in[OUT_VSYNC]),
    .rise    (vrise)
  );

  assign good    = hrise & (hcount == H_LAST);
  assign bad     = hrise & (hcount != H_LAST);
  assign timeout = ~hrise & (hcount == H_LAST);
  assign vzero   = hrise & (vpend | vrise);
  assign overrun = hrise & ~(vpend | vrise)
                 & (vcount == V_LAST);
  assign locked  = (state == VS_RUN);

  // Colour half of the sample register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s0_rgb <= 6'h3F;
    else          s0_rgb <= out_in[5:0];
  end

  // hcount tracks the line index of the sample in s0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             hcount <= H_END;
    else if (hrise)           hcount <= 8'd0;
    else if (hcount != H_END) hcount <= hcount + 8'd1;
  end

  // Line counter, zeroed on the first hsync after vsync
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcount <= 10'd0;
      vpend  <= 1'b0;
    end else if (vzero) begin
      vcount <= 10'd0;
      vpend  <= 1'b0;
    end else if (hrise) begin
      vcount <= vcount + 10'd1;
    end else if (vrise) begin
      vpend  <= 1'b1;
    end
  end

  // State, lock counter and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= VS_SEARCH;
      lockcnt     <= 3'd0;
      sync_err    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      lockcnt     <= lock_n;
      sync_err    <= err_n;
      line_start  <= ls_n;
      frame_start <= fs_n;
    end
  end

  // Lock FSM; faults win over pixel emission
  always_comb begin
    state_n = state;
    lock_n  = lockcnt;
    err_n   = 1'b0;
    ls_n    = 1'b0;
    fs_n    = 1'b0;
    run_ok  = 1'b0;
    unique case (state)
      VS_SEARCH: begin
        if (hrise) begin
          state_n = VS_HLOCK;
          lock_n  = 3'd0;
        end
      end
      VS_HLOCK: begin
        if (timeout) begin
          state_n = VS_SEARCH;
        end else if (good) begin
          if (lockcnt + 3'd1 == LOCK_N) begin
            state_n = VS_WAIT_V;
            lock_n  = 3'd0;
          end else begin
            lock_n  = lockcnt + 3'd1;
          end
        end else if (bad) begin
          lock_n = 3'd0;
        end
      end
      VS_WAIT_V: begin
        if (bad) begin
          err_n   = 1'b1;
          state_n = VS_HLOCK;
          lock_n  = 3'd0;
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = VS_SEARCH;
        end else if (vzero) begin
          state_n = VS_RUN;
          fs_n    = 1'b1;
        end
      end
      VS_RUN: begin
        if (bad) begin
          err_n   = 1'b1;
          state_n = VS_HLOCK;
          lock_n  = 3'd0;
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = VS_SEARCH;
        end else if (overrun) begin
          err_n   = 1'b1;
          state_n = VS_WAIT_V;
        end else begin
          run_ok = 1'b1;
          ls_n   = hrise;
          fs_n   = vzero;
        end
      end
      default: state_n = VS_SEARCH;
    endcase
  end

  assign pix_vis = run_ok
                 & (hcount >= H_LO) & (hcount < H_HI)
                 & (vcount >= V_LO) & (vcount < V_HI);

  // Registered pixel stream; fields hold between pixels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_rgb   <= 6'd0;
      pix_x     <= 8'd0;
      pix_y     <= 9'd0;
    end else begin
      pix_valid <= pix_vis;
      if (pix_vis) begin
        pix_rgb <= s0_rgb;
        pix_x   <= hcount - H_LO;
        pix_y   <= 9'(vcount - V_LO);
      end
    end
  end

endmodule

// File: tb/tb_gigatron_video_sampler.sv
// tb_gigatron_video_sampler: directed sync streams with
// hand-computed pixel counts, pulses and lock state.
module tb_gigatron_video_sampler;

  localparam int HT  = 200;
  localparam int HBP = 11;
  localparam int HV  = 160;
  localparam int VT  = 24;
  localparam int VBP = 3;
  localparam int VV  = 18;
  localparam int LL  = 4;

  localparam int V_PEND = 0;
  localparam int V_COIN = 1;
  localparam int V_NONE = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_in  = 8'hFF;
  logic       pix_valid;
  logic [5:0] pix_rgb;
  logic [7:0] pix_x;
  logic [8:0] pix_y;
  logic       line_start;
  logic       frame_start;
  logic       sync_err;
  logic       locked;

  int n_run  = 0;
  int n_fail = 0;
  int n_valid, n_ls, n_fs, n_err, mon_err;
  int ex, ey, cur_line;
  int first_x, first_y, first_ln, last_x, last_y;
  bit got_first;

  gigatron_video_sampler #(
    .H_TOTAL    (HT),
    .H_BP       (HBP),
    .H_VIS      (HV),
    .V_TOTAL    (VT),
    .V_BP       (VBP),
    .V_VIS      (VV),
    .LOCK_LINES (LL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .out_in      (out_in),
    .pix_valid   (pix_valid),
    .pix_rgb     (pix_rgb),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int line,
    input int h, input int len, input int vmode);
    logic hs, vs;
    logic [5:0] rgb;
    hs = (h < len - 12);
    vs = 1'b1;
    if (vmode == V_PEND &&
        ((line == VT-2 && h >= 50) ||
         (line == VT-1 && h < 100)))
      vs = 1'b0;
    if (vmode == V_COIN && line == VT-1 && h >= 50)
      vs = 1'b0;
    rgb = 6'(h - HBP);
    return {vs, hs, rgb};
  endfunction

  task automatic clr();
    n_valid = 0; n_ls = 0; n_fs = 0;
    n_err = 0; mon_err = 0; got_first = 0;
  endtask

  task automatic sample();
    if (pix_valid) begin
      n_valid++;
      if (!got_first) begin
        got_first = 1;
        first_x = int'(pix_x);
        first_y = int'(pix_y);
        first_ln = cur_line;
      end
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      if (int'(pix_x) != ex || int'(pix_y) != ey ||
          pix_rgb != 6'(ex))
        mon_err++;
      ex++;
      if (ex == HV) begin
        ex = 0;
        ey++;
      end
    end
    if (line_start)  n_ls++;
    if (frame_start) n_fs++;
    if (sync_err)    n_err++;
  endtask

  task automatic cyc(input int line, input int h,
                     input int len, input int vmode);
    @(negedge clk);
    sample();
    cur_line = line;
    out_in = pat(line, h, len, vmode);
  endtask

  task automatic run_lines(input int first,
    input int last, input int vmode, input int short_ln);
    int len;
    if (first == 0) begin
      ex = 0;
      ey = 0;
    end
    for (int l = first; l <= last; l++) begin
      len = (l == short_ln) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) cyc(l, h, len, vmode);
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample();
      out_in = 8'hBF;
      if (i == 0) begin
        @(posedge clk);
        #1;
        check("tmo_pulse", int'(sync_err), 1);
      end
    end
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(pix_valid), 0);
    check("rst_rgb",   int'(pix_rgb),   0);
    check("rst_x",     int'(pix_x),     0);
    check("rst_y",     int'(pix_y),     0);
    check("rst_ls",    int'(line_start), 0);
    check("rst_fs",    int'(frame_start), 0);
    check("rst_err",   int'(sync_err),  0);
    check("rst_lock",  int'(locked),    0);
    @(negedge clk);
    reset_n = 1'b1;

    // acquire: 1 + LL hsync rises then vsync
    clr();
    run_lines(VT-6, VT-1, V_PEND, -1);
    check("pre_lock",  int'(locked), 0);
    check("pre_valid", n_valid, 0);
    check("pre_err",   n_err, 0);

    // frame 1, ends with coincident vsync/hsync
    clr();
    run_lines(0, VT-1, V_COIN, -1);
    check("f1_lock",  int'(locked), 1);
    check("f1_fs",    n_fs, 1);
    check("f1_ls",    n_ls, VT-1);
    check("f1_count", n_valid, HV*VV);
    check("f1_fx",    first_x, 0);
    check("f1_fy",    first_y, 0);
    check("f1_fln",   first_ln, VBP);
    check("f1_lx",    last_x, HV-1);
    check("f1_ly",    last_y, VV-1);
    check("f1_pix",   mon_err, 0);
    check("f1_err",   n_err, 0);

    // frame 2 starts on the coincident edge
    clr();
    run_lines(0, VT-1, V_PEND, -1);
    check("coin_fs",    n_fs, 1);
    check("coin_ls",    n_ls, VT);
    check("coin_count", n_valid, HV*VV);
    check("coin_fln",   first_ln, VBP);
    check("coin_pix",   mon_err, 0);
    check("coin_err",   n_err, 0);

    // frame 3: one 199-clock line at row 10
    clr();
    run_lines(0, VT-1, V_PEND, 10);
    check("short_err",   n_err, 1);
    check("short_count", n_valid, HV*(10-VBP+1));
    check("short_pix",   mon_err, 0);
    check("short_lock",  int'(locked), 0);

    // frame 4: relocked
    clr();
    run_lines(0, VT-1, V_PEND, -1);
    check("relock",       int'(locked), 1);
    check("relock_fs",    n_fs, 1);
    check("relock_count", n_valid, HV*VV);
    check("relock_pix",   mon_err, 0);
    check("relock_err",   n_err, 0);

    // frame 5: hsync held low after row 7
    clr();
    run_lines(0, 7, V_PEND, -1);
    check("hold_pre", n_valid, HV*(7-VBP+1));
    clr();
    hold_low(250);
    check("hold_lock", int'(locked), 0);
    run_lines(8, VT-1, V_PEND, -1);
    check("hold_valid", n_valid, 0);
    check("hold_err",   n_err, 1);
    check("hold_wait",  int'(locked), 0);

    // frame 6 runs, then vsync is withheld
    clr();
    run_lines(0, VT-1, V_NONE, -1);
    check("f6_lock",  int'(locked), 1);
    check("f6_count", n_valid, HV*VV);
    check("f6_err",   n_err, 0);

    // frame 7: overrun on line VT, then wait for vsync
    clr();
    run_lines(0, 0, V_PEND, -1);
    check("ovr_err",  n_err, 1);
    check("ovr_lock", int'(locked), 0);
    run_lines(1, VT-1, V_PEND, -1);
    check("ovr_valid", n_valid, 0);
    check("ovr_err2",  n_err, 1);

    // frame 8: async reset in the middle of row 10
    clr();
    run_lines(0, 9, V_PEND, -1);
    check("f8_lock", int'(locked), 1);
    for (int h = 0; h < 50; h++) cyc(10, h, HT, V_PEND);
    check("mid_valid", int'(pix_valid), 1);
    check("mid_y",     int'(pix_y), 10 - VBP);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", int'(pix_valid), 0);
    check("ar_rgb",   int'(pix_rgb), 0);
    check("ar_x",     int'(pix_x), 0);
    check("ar_y",     int'(pix_y), 0);
    check("ar_lock",  int'(locked), 0);
    for (int h = 50; h < 60; h++) cyc(10, h, HT, V_PEND);
    #2 reset_n = 1'b1;
    clr();
    for (int h = 60; h < HT; h++) cyc(10, h, HT, V_PEND);
    run_lines(11, VT-1, V_PEND, -1);
    check("post_err",   n_err, 0);
    check("post_valid", n_valid, 0);
    check("post_ls",    n_ls, 0);
    check("post_wait",  int'(locked), 0);
    run_lines(0, VBP, V_PEND, -1);
    check("post_lock", int'(locked), 1);
    check("post_fs",   n_fs, 1);
    check("post_err2", n_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/gigatron_video_sampler.md
# gigatron_video_sampler

Downstream consumer of the Gigatron core's `out` register, driven by the same clock as the core. It decodes the core's hsync (out[6], active low) and vsync (out[7], active low). It locks onto the line and frame timing and emits a coordinate-tagged pixel stream (out[5:0] RGB222) for a framebuffer writer or a scan-converter. Sync faults are reported, and lock is reacquired without software help.

## Interface
- `H_TOTAL`, 200: clocks per scanline.
- `H_BP`, 11: clocks from the hsync rising edge (index 0) to the first visible pixel.
- `H_VIS`, 160: visible pixels per line.
- `V_TOTAL`, 521: maximum lines per frame.
- `V_BP`, 33: lines from the frame start to the first visible line.
- `V_VIS`, 480: visible lines.
- `LOCK_LINES`, 4: consecutive good lines required before horizontal lock.

Ports:
- `clk`, in, 1: core clock. One clock domain for the whole block.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `out_in`, in, 8: the core's `out` register, sampled every cycle.
- `pix_valid`, out, 1: a visible pixel is present this cycle.
- `pix_rgb`, out, 6: pixel colour (out[5:0]).
- `pix_x`, out, 8: pixel column, 0..H_VIS-1.
- `pix_y`, out, 9: pixel row, 0..V_VIS-1.
- `line_start`, out, 1: one-cycle pulse at each hsync rise while in RUN.
- `frame_start`, out, 1: one-cycle pulse when the line counter is zeroed in RUN.
- `sync_err`, out, 1: one-cycle pulse on any timing fault while in WAIT_V or RUN.
- `locked`, out, 1: high while the state is RUN.

## Operation
- **Sample register and edge detection**
  - `s0 <= out_in` every cycle.
  - `hrise = out_in[6] & ~s0[6]`.
  - `vrise = out_in[7] & ~s0[7]`.
- **Horizontal counter (`hcount`, 8 bits)**
  - On `hrise`: `hcount <= 0`, so `hcount` is the line index of the sample now held in `s0`.
  - Otherwise `hcount` increments, saturating at H_TOTAL.
  - A line is good when `hrise` occurs with the old `hcount == H_TOTAL-1`.
  - A line is bad when `hrise` occurs with any other old `hcount`.
  - Timeout: `hcount` reaches H_TOTAL with no `hrise`.
- **Vertical counter and vsync handling**
  - `vrise` sets `vpend`.
  - On `hrise` with `vpend` (or with `vrise` in the same cycle): `vcount <= 0` and `vpend` is cleared.
  - On any other `hrise`: `vcount` increments.
  - `vcount` is 10 bits wide.
- **State machine: SEARCH, HLOCK, WAIT_V, RUN**
  - SEARCH: the first `hrise` moves to HLOCK with `lockcnt = 0`.
  - HLOCK:
    - A good line increments `lockcnt`; at LOCK_LINES the state moves to WAIT_V.
    - A bad line clears `lockcnt`.
    - A timeout moves to SEARCH.
  - WAIT_V: an `hrise` that zeroes `vcount` moves to RUN and pulses `frame_start`.
  - RUN and WAIT_V faults:
    - A bad line pulses `sync_err` and moves to HLOCK with `lockcnt = 0`.
    - A timeout pulses `sync_err` and moves to SEARCH.
  - RUN vertical overrun: `hrise` with no vsync pending while `vcount == V_TOTAL-1` pulses `sync_err` and moves to WAIT_V.
  - RUN faults take priority over pixel emission in the same cycle.
- **Pixel output (registered)**
  - `pix_valid <= RUN & H_BP <= hcount < H_BP+H_VIS & V_BP <= vcount < V_BP+V_VIS`.
  - `pix_rgb <= s0[5:0]`.
  - `pix_x <= hcount-H_BP`.
  - `pix_y <= vcount-V_BP`.
  - All pixel fields are truncated to their port widths.
  - `pix_rgb`, `pix_x` and `pix_y` update only when the new `pix_valid` is 1; otherwise they hold.
- **Reset mid-frame**: every register returns to its reset value immediately, and lock must be reacquired from scratch.

## Timing
- Reset values:
  - `state = SEARCH`; `s0 = 8'hFF`, so no false edge is seen after reset.
  - `hcount = H_TOTAL`, `vcount = 0`, `vpend = 0`, `lockcnt = 0`.
  - All outputs are 0.
- Latency: an `out_in` value sampled at edge n appears on `pix_*` after edge n+1 (2 clocks).
- Pulse alignment:
  - `line_start` and `frame_start` are asserted in the cycle after the `hrise` edge.
  - `sync_err` is asserted in the cycle after the faulting edge.
- Lock time: a clean input reaches RUN no earlier than LOCK_LINES+1 hsync rises plus the wait for vsync.

## Structure
- Shared package `gigatron_video_pkg` holds:
  - the state encoding (`VS_SEARCH`, `VS_HLOCK`, `VS_WAIT_V`, `VS_RUN`);
  - the default timing constants;
  - the out-bit positions `OUT_HSYNC = 6` and `OUT_VSYNC = 7`.
- One sub-module, `gigatron_sync_edge`: the sample register plus the rising-edge detector, instantiated for both hsync and vsync.
- The counters and the FSM stay in the top-level block.

## Test plan
- **Clean stream.** Drive an ideal 200×521 stream with pixel value = x&63.
  - `locked` rises after 4 good lines plus one vsync.
  - Exactly 160×480 `pix_valid` cycles per frame.
  - The first pixel has `pix_x = 0`, `pix_y = 0`; the last has `pix_x = 159`, `pix_y = 479`.
  - `pix_rgb` matches at 2-clock latency.
- **Short line.** One 199-clock line while in RUN.
  - `sync_err` pulses once and `locked` drops.
  - The block relocks after 4 lines plus vsync, with no `pix_valid` in between.
- **Missing hsync.** Hold out[6] low while in RUN.
  - `sync_err` pulses when `hcount` hits 200; state is SEARCH and `pix_valid` stays 0.
- **Coincident edges.** vsync rise and hsync rise in the same cycle.
  - `vcount` becomes 0 on that edge and `frame_start` pulses once.
- **No vsync.** Suppress vsync for one frame.
  - `sync_err` pulses at line 521 and the state moves to WAIT_V.
  - The block returns to RUN on the next vsync.
- **Reset mid-frame.** Assert `reset_n = 0` mid-frame, asynchronously between clock edges.
  - All outputs go to 0 at once, without waiting for a clock edge.
  - After release, no spurious `hrise` is detected and no `sync_err` pulses.
